// File: rtl/fpu_normalize.sv
// rtl/fpu_normalize.sv - post-add normalization, truncation and packing for the 32-bit custom float
module fpu_normalize #(
    parameter int BIAS    = 31,
    parameter int EXP_MAX = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [5:0]  in_exp,
    input  logic [26:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT_R,
        S_SHIFT_L,
        S_PACK
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic [6:0]  exp_q;
    logic [26:0] mant_q;
    logic        inexact_q;
    logic        valid_q;
    logic [31:0] data_q;
    logic [3:0]  status_q;

    logic [26:0] mant_sl_d;
    logic [6:0]  exp_dec_d;
    logic [31:0] data_d;
    logic [3:0]  status_d;
    logic        is_zero;
    logic        is_uflow;
    logic        is_oflow;

    always_comb begin
        mant_sl_d = mant_q << 1;
        exp_dec_d = exp_q - 7'd1;
        is_zero   = (mant_q == 27'h0);
        // Anything still unnormalized, or normalized only by borrowing code 0, is flushed.
        is_uflow  = (exp_q == 7'd0) || !mant_q[25];
        is_oflow  = (exp_q >= 7'(EXP_MAX));
        data_d    = {sign_q, exp_q[5:0], mant_q[24:0]};
        status_d  = {inexact_q, 3'b000};
        if (is_zero) begin
            data_d   = 32'h0;
            status_d = 4'b0001;
        end else if (is_uflow) begin
            data_d   = {sign_q, 31'h0};
            status_d = 4'b1101;
        end else if (is_oflow) begin
            data_d   = {sign_q, 6'(EXP_MAX), 25'h0};
            status_d = {inexact_q, 3'b010};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= 7'd0;
            mant_q    <= 27'h0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 32'h0;
            status_q  <= 4'h0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q    <= in_sign;
                        exp_q     <= {1'b0, in_exp};
                        mant_q    <= in_mant;
                        inexact_q <= in_sticky;
                        state_q   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mant_q == 27'h0 || exp_q == 7'd0) begin
                        state_q <= S_PACK;
                    end else if (mant_q[26]) begin
                        state_q <= S_SHIFT_R;
                    end else if (mant_q[25]) begin
                        state_q <= S_PACK;
                    end else begin
                        state_q <= S_SHIFT_L;
                    end
                end
                S_SHIFT_R: begin
                    mant_q    <= mant_q >> 1;
                    exp_q     <= exp_q + 7'd1;
                    inexact_q <= inexact_q | mant_q[0];
                    state_q   <= S_PACK;
                end
                S_SHIFT_L: begin
                    mant_q <= mant_sl_d;
                    exp_q  <= exp_dec_d;
                    // Stop once normalized or once the exponent can go no lower.
                    if (mant_sl_d[25] || exp_dec_d <= 7'd1) begin
                        state_q <= S_PACK;
                    end
                end
                S_PACK: begin
                    data_q   <= data_d;
                    status_q <= status_d;
                    valid_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule
